pipe_delay_fifo: RTL
====================

// Module: pipe_delay_fifo
// PURPOSE
//  Elastic buffer directly downstream of the fixed-latency pipe_delay stage in the TE->TC chain.
//  - pipe_delay has no backpressure, so this block absorbs its delayed words and presents them
//    to the tracklet-calculator input with a valid/ready handshake.
//  - almost_full is sized so the producer can stop issuing while SKID words are still in flight.
// PARAMETERS
//  WIDTH  25  data word width; matches pipe_delay WIDTH
//  DEPTH  16  storage entries; power of 2, >= 4
//  SKID   3   words in flight upstream; set equal to pipe_delay STAGES; must be < DEPTH
//  ADDR   $clog2(DEPTH)  derived; not for override
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  din          in   WIDTH    word from pipe_delay val_out
//  din_valid    in   1        din is a real word this cycle
//  almost_full  out  1        count >= DEPTH-SKID; producer stops issuing new words
//  dout         out  WIDTH    head-of-queue word (show-ahead)
//  dout_valid   out  1        queue non-empty
//  dout_ready   in   1        consumer accepts dout this cycle
//  flush        in   1        synchronous event-boundary clear
//  count        out  ADDR+1   current occupancy, 0..DEPTH
//  overflow     out  1        sticky: a word was dropped because the queue was full
// BEHAVIOUR
//  - Reset: all outputs 0; rd_ptr, wr_ptr and count 0; memory contents not reset.
//  - pop  = dout_valid & dout_ready.
//  - push = din_valid & (count<DEPTH | pop).
//  - Push writes mem[wr_ptr] and increments wr_ptr; pop increments rd_ptr.
//  - Both pointers wrap modulo DEPTH.
//  - count' = count + push - pop. Occupancy is tracked by count, not by pointer compare.
//  - dout_valid = (count != 0), from registered state.
//  - dout = mem[rd_ptr] when dout_valid, else 0 (masked; never X).
//  - Latency: push at edge N into an empty queue gives dout_valid=1 and dout=din after edge N,
//    i.e. 1 cycle.
//  - Full + push + pop: both occur, count stays DEPTH, no overflow.
//  - Full + push, no pop: word dropped; overflow=1 from the next cycle; count, pointers and
//    memory unchanged.
//  - Empty + dout_ready: no pop, no pointer movement.
//  - almost_full = (count >= DEPTH-SKID), combinational from count.
//    This guarantees no overflow if the producer honours it within SKID cycles.
//  - flush=1: next cycle count=0, pointers=0, dout_valid=0.
//    - flush beats a simultaneous push or pop; that word is discarded.
//    - overflow is NOT cleared by flush, only by reset.
//  - reset beats flush. Reset mid-stream discards all contents; outputs are at reset values
//    on the next cycle.
//  - No combinational path from dout_ready to dout_valid or almost_full.
// CONFIGURATION
//  PIPE_FIFO_PEAK_EN defined:
//   - adds port peak (out, ADDR+1) = max count seen since the last reset or flush.
//   - peak updates 1 cycle after count; reset and flush return it to 0.
//  PIPE_FIFO_PEAK_EN undefined:
//   - peak port and its logic are absent; all other behaviour identical.
// TESTING
//  1. Reset, then din=0x1ABCDE with din_valid for 1 cycle, dout_ready=1
//     -> next cycle dout_valid=1, dout=0x1ABCDE; following cycle dout_valid=0, count=0.
//  2. dout_ready=0, push 13 words (DEPTH=16, SKID=3) -> almost_full=1 once count=13,
//     and 0 while count=12.
//  3. Fill to 16, push 0x55 with dout_ready=0 -> overflow=1, count=16, head unchanged;
//     then drain 16 -> original order, no 0x55.
//  4. Full queue, push and pop each cycle for 20 cycles -> count stays 16, order preserved,
//     overflow=0, pointers wrap.
//  5. count=7, assert flush together with din_valid and dout_ready
//     -> next cycle count=0, dout_valid=0, dout=0; overflow keeps its prior value.
//  6. PIPE_FIFO_PEAK_EN: fill to 9, drain to 2 -> peak=9; flush -> peak=0; reset mid-fill
//     -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pipe_delay_fifo.sv
// pipe_delay_fifo
//   Elastic buffer that sits directly after the fixed-latency pipe_delay stage.
//   pipe_delay cannot be back-pressured, so every delayed word is absorbed here
//   and handed to the tracklet-calculator input over a valid/ready handshake.
//   almost_full asserts while there is still room for SKID in-flight words.
//
// Optional feature macro: PIPE_FIFO_PEAK_EN
//   When defined, this adds output 'peak': the highest occupancy seen since the
//   last reset or flush. It follows count with one cycle of lag.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high
//   din          in   WIDTH    word from pipe_delay
//   din_valid    in   1        din carries a real word this cycle
//   almost_full  out  1        count >= DEPTH-SKID; producer must stop issuing
//   dout         out  WIDTH    head-of-queue word (show-ahead), 0 when empty
//   dout_valid   out  1        queue non-empty
//   dout_ready   in   1        consumer takes dout this cycle
//   flush        in   1        synchronous clear at event boundaries
//   count        out  ADDR+1   occupancy, 0..DEPTH
//   overflow     out  1        sticky; a word was dropped on a full queue
//   peak         out  ADDR+1   (PIPE_FIFO_PEAK_EN only) max occupancy seen

module pipe_delay_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    parameter int SKID  = 3,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             almost_full,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             flush,
    output logic [ADDR:0]    count,
`ifdef PIPE_FIFO_PEAK_EN
    output logic [ADDR:0]    peak,
`endif
    output logic             overflow
);

    localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] AF_CNT   = (ADDR+1)'(DEPTH - SKID);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  rd_ptr;
    logic [ADDR-1:0]  wr_ptr;
    logic             full;
    logic             pop;
    logic             push;

    // All flags come from registered count, so dout_ready never reaches
    // dout_valid or almost_full combinationally.
    assign full        = (count == FULL_CNT);
    assign dout_valid  = (count != '0);
    assign almost_full = (count >= AF_CNT);
    assign pop         = dout_valid & dout_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push        = din_valid & (~full | pop);

    assign dout = dout_valid ? mem[rd_ptr] : '0;

    // The storage array has no reset. A dropped or flushed word is never written.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            // overflow is sticky across flush; only reset clears it.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (din_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PIPE_FIFO_PEAK_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            peak <= '0;
        end else if (count > peak) begin
            peak <= count;
        end
    end
`endif

endmodule
